enum_job_controller: RTL
========================

ENUM_JOB_CONTROLLER -- requirements
Module: enum_job_controller

Interface
REQ-001 Parameter MAX_ROWS, default 4, max matrix rows per job.
REQ-002 Parameter MAX_COLS, default 7, max matrix columns (variables plus augmented column).
REQ-003 Parameter SUM_W, default 16, width of the running total.
REQ-004 Localparams MAX_ROWS_W/MAX_COLS_W SHALL be $clog2(N+1), with a floor of 1 when N<=1.
REQ-005 Port clk  in  1  sole clock; all logic on posedge.
REQ-006 Port rst_n  in  1  reset, synchronous, active-low.
REQ-007 Port job_valid  in  1  job descriptor offered.
REQ-008 Port job_ready  out  1  controller accepts the descriptor.
REQ-009 Port job_rows  in  MAX_ROWS_W  row count of the offered job.
REQ-010 Port job_cols  in  MAX_COLS_W  column count of the offered job.
REQ-011 Port job_rref  in  [MAX_COLS-1:0] x [MAX_ROWS-1:0] unpacked  RREF matrix of the offered job.
REQ-012 Port enum_rows/enum_cols/enum_rref  out  same widths  registered config driven to enumerate_solutions.
REQ-013 Port enum_start  out  1  single-cycle start pulse to enumerate_solutions.
REQ-014 Port sol_stream  axi_stream_if receiver  DATA_WIDTH 8  solutions; tdata = press count, tlast marks the final solution.
REQ-015 Port res_tvalid/res_tready/res_tdata[7:0]  out/in/out  per-job minimum press count.
REQ-016 Port total  out  SUM_W  saturating sum of all emitted minima.
REQ-017 Port jobs_done  out  16  count of results accepted downstream.

Function
REQ-018 The FSM SHALL have states IDLE, START, COLLECT and EMIT, with the encoding held in the package.
REQ-019 IDLE: job_ready=1; on job_valid&&job_ready, the controller SHALL register rows/cols/rref into enum_* and go to START.
REQ-020 START: enum_start=1 for exactly one cycle, min_reg set to 8'hFF, then go to COLLECT.
REQ-021 COLLECT: sol_stream.tready=1; on each beat min_reg<=min(min_reg,tdata); on a beat with tlast, go to EMIT.
REQ-022 EMIT: res_tvalid=1, res_tdata=min_reg held stable until res_tready; on handshake, total<=sat(total+min_reg), jobs_done++, go to IDLE.
REQ-023 enum_rows/enum_cols/enum_rref SHALL stay constant from the accept cycle until the EMIT handshake.
REQ-024 job_ready SHALL be 0 in every state except IDLE; back-to-back jobs cost at least 4 cycles each.
REQ-025 sol_stream.tready SHALL be 0 outside COLLECT, and beats presented outside COLLECT SHALL NOT alter min_reg.
REQ-026 A tlast beat's tdata SHALL be included in the minimum.
REQ-027 total SHALL saturate at 2^SUM_W-1 and never wrap; jobs_done SHALL wrap modulo 2^16.
REQ-028 If res_tvalid and res_tready are both high in the cycle EMIT is entered, the handshake SHALL complete that cycle.
REQ-029 Latency: enum_start SHALL assert 1 cycle after job acceptance, and res_tvalid SHALL assert 1 cycle after the tlast beat.

Reset
REQ-030 On rst_n=0 at posedge: state=IDLE, enum_start=0, res_tvalid=0, res_tdata=0, total=0, jobs_done=0, min_reg=8'hFF, enum_rows=0, enum_cols=0, enum_rref all 0.
REQ-031 While rst_n=0, job_ready and sol_stream.tready SHALL be 0.
REQ-032 Reset asserted mid-COLLECT or mid-EMIT SHALL abandon the job; no result is emitted and total is cleared.

Structure
REQ-033 Package enum_ctrl_pkg SHALL hold the state enum, the 8'hFF min-init constant, and the MAX_*_W width function.
REQ-034 No sub-module; enumerate_solutions is instantiated by the parent, not inside this block.

Verification
REQ-035 One job, stream 5,3,7(tlast), res_tready=1 -> res_tdata=3, total=3, jobs_done=1, exactly one enum_start pulse.
REQ-036 Single beat 2 with tlast -> res_tdata=2, and res_tvalid rises the cycle after the beat.
REQ-037 res_tready held 0 for 10 cycles in EMIT -> res_tdata stable, job_ready=0, stream tready=0, total unchanged until the handshake.
REQ-038 Two queued jobs with minima 4 then 1 -> total=5, jobs_done=2, enum_rref changes only after the first EMIT handshake.
REQ-039 SUM_W=4 with minima 9 then 9 -> total=15 (saturated).
REQ-040 rst_n pulsed low during COLLECT after beat 1 -> no res_tvalid, total=0, state IDLE, job_ready=1 the cycle after release.

Source files
------------

// File: rtl/enum_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// enum_ctrl_pkg
// Shared definitions for the enumeration job controller:
//   state_t     - controller FSM encoding (IDLE, START, COLLECT, EMIT)
//   MIN_INIT    - value the running minimum starts from for every job
//   idx_width() - width needed to hold a count 0..n (never less than 1)
// -----------------------------------------------------------------------------
package enum_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      COLLECT = 2'd2,
      EMIT    = 2'd3
   } state_t;

   // Largest possible press count, so the first beat always replaces it.
   localparam logic [7:0] MIN_INIT = 8'hFF;

   // Width of a counter that must represent every value from 0 to n.
   function automatic int idx_width(input int n);
      if (n <= 1) begin
         return 1;
      end
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/axi_stream_if.sv
// -----------------------------------------------------------------------------
// axi_stream_if
// Minimal AXI-Stream bundle: tvalid/tready handshake, tdata, tlast.
//   transmitter - drives tvalid/tdata/tlast, samples tready
//   receiver    - samples tvalid/tdata/tlast, drives tready
// -----------------------------------------------------------------------------
interface axi_stream_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;

   modport transmitter (output tvalid, output tdata, output tlast, input tready);
   modport receiver    (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/enum_job_controller.sv
// -----------------------------------------------------------------------------
// enum_job_controller
// Accepts one matrix job at a time, hands its configuration to an external
// solution enumerator, tracks the minimum press count over the returned
// solution stream and emits that minimum as a one-beat result.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   job_valid/job_ready         job descriptor handshake
//   job_rows/job_cols/job_rref  offered job configuration
//   enum_rows/enum_cols/enum_rref  configuration held for the enumerator
//   enum_start                  one-cycle start pulse to the enumerator
//   sol_stream                  solution stream (tdata = press count)
//   res_tvalid/res_tready/res_tdata  per-job minimum result
//   total                       saturating sum of all emitted minima
//   jobs_done                   wrapping count of accepted results
// -----------------------------------------------------------------------------
module enum_job_controller
   import enum_ctrl_pkg::*;
#(
   parameter  int MAX_ROWS   = 4,
   parameter  int MAX_COLS   = 7,
   parameter  int SUM_W      = 16,
   localparam int MAX_ROWS_W = idx_width(MAX_ROWS),
   localparam int MAX_COLS_W = idx_width(MAX_COLS)
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic [MAX_ROWS_W-1:0] job_rows,
   input  logic [MAX_COLS_W-1:0] job_cols,
   input  logic [MAX_COLS-1:0]   job_rref [MAX_ROWS],

   output logic [MAX_ROWS_W-1:0] enum_rows,
   output logic [MAX_COLS_W-1:0] enum_cols,
   output logic [MAX_COLS-1:0]   enum_rref [MAX_ROWS],
   output logic                  enum_start,

   axi_stream_if.receiver        sol_stream,

   output logic                  res_tvalid,
   input  logic                  res_tready,
   output logic [7:0]            res_tdata,

   output logic [SUM_W-1:0]      total,
   output logic [15:0]           jobs_done
);

   // Adder is wide enough for both the total and an 8-bit minimum, plus carry,
   // so the saturation test also works when SUM_W is narrower than 8.
   localparam int              ACC_W   = ((SUM_W > 8) ? SUM_W : 8) + 1;
   localparam logic [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << SUM_W) - ACC_W'(1);

   state_t                  state_reg;
   state_t                  state_next;
   logic [7:0]              min_reg;
   logic [7:0]              res_data_reg;
   logic [SUM_W-1:0]        total_reg;
   logic [15:0]             jobs_done_reg;
   logic [MAX_ROWS_W-1:0]   rows_reg;
   logic [MAX_COLS_W-1:0]   cols_reg;
   logic [MAX_COLS-1:0]     rref_reg [MAX_ROWS];

   logic                    job_fire;
   logic                    beat_fire;
   logic                    res_fire;
   logic [7:0]              beat_min;
   logic [ACC_W-1:0]        acc_sum;
   logic [SUM_W-1:0]        total_sat;

   // Handshake-facing outputs are gated by rst_n so nothing is offered or
   // accepted while reset is held.
   assign job_ready         = rst_n && (state_reg == IDLE);
   assign sol_stream.tready = rst_n && (state_reg == COLLECT);
   assign enum_start        = rst_n && (state_reg == START);
   assign res_tvalid        = rst_n && (state_reg == EMIT);
   assign res_tdata         = res_data_reg;

   assign job_fire  = job_valid && job_ready;
   assign beat_fire = sol_stream.tvalid && sol_stream.tready;
   assign res_fire  = res_tvalid && res_tready;

   // The tlast beat takes part in the minimum like any other beat.
   assign beat_min  = (sol_stream.tdata < min_reg) ? sol_stream.tdata : min_reg;

   always_comb begin
      acc_sum   = ACC_W'(total_reg) + ACC_W'(res_data_reg);
      total_sat = (acc_sum > SAT_MAX) ? {SUM_W{1'b1}} : acc_sum[SUM_W-1:0];
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (job_fire) state_next = START;
         START:   state_next = COLLECT;
         COLLECT: if (beat_fire && sol_stream.tlast) state_next = EMIT;
         EMIT:    if (res_fire) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         min_reg       <= MIN_INIT;
         res_data_reg  <= 8'd0;
         total_reg     <= '0;
         jobs_done_reg <= 16'd0;
         rows_reg      <= '0;
         cols_reg      <= '0;
      end else begin
         state_reg <= state_next;

         if (job_fire) begin
            rows_reg <= job_rows;
            cols_reg <= job_cols;
         end

         if (state_reg == START) begin
            min_reg <= MIN_INIT;
         end else if (beat_fire) begin
            min_reg <= beat_min;
            // Capture the final minimum directly so the result is valid in
            // the very next cycle without reading min_reg a second time.
            if (sol_stream.tlast) begin
               res_data_reg <= beat_min;
            end
         end

         if (res_fire) begin
            total_reg     <= total_sat;
            jobs_done_reg <= jobs_done_reg + 16'd1;
         end
      end
   end

   // Only job_fire loads the matrix, and job_fire is possible only in IDLE,
   // so the configuration is frozen for the lifetime of each job.
   generate
      for (genvar gi = 0; gi < MAX_ROWS; gi++) begin : g_rref_row
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rref_reg[gi] <= '0;
            end else if (job_fire) begin
               rref_reg[gi] <= job_rref[gi];
            end
         end
         assign enum_rref[gi] = rref_reg[gi];
      end
   endgenerate

   assign enum_rows = rows_reg;
   assign enum_cols = cols_reg;
   assign total     = total_reg;
   assign jobs_done = jobs_done_reg;

endmodule
